maze_renderer: RTL
==================

# maze_renderer

Downstream consumer of the maze carver: snapshots the 256-bit maze bitmap when the carver signals completion, then continuously scans it out as a 640x480@60 Hz VGA image of 16x16 tiles with the player marker overlaid. Sits between the carver/player logic and the board's VGA DAC pins; contains its own timing generator, tile counters and a 2-stage pixel pipeline.

## Interface
- H_VIS, 640, visible pixels per line
- V_VIS, 480, visible lines per frame
- TILE_PX, 30, tile edge in pixels (16 x 30 = 480)
- X_ORG, 80, first pixel column of the maze area
- clk  in  1  25 MHz pixel clock, single clock domain
- rst_n  in  1  synchronous, active-low reset
- maze_data  in  256  carved bitmap, cell (x,y) at bit x + 16*y, 1 = path, 0 = wall
- maze_done  in  1  carver's finish flag; a rising edge marks maze_data as complete
- player_x  in  4  player column, 0..15
- player_y  in  4  player row, 0..15
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- rgb  out  8  pixel colour, {R[2:0],G[2:0],B[1:0]}
- frame_start  out  1  one-cycle pulse, first visible pixel of each frame

## Operation
- Reset: hcount=0, vcount=0, hsync=1, vsync=1, rgb=8'h00, frame_start=0, snapshot=0, load FSM in IDLE.
- Timing generator: hcount 0..799 (visible 0..639, front 16, sync 656..751, back 48); vcount 0..524 increments on hcount wrap 799->0 (visible 0..479, sync 490..491). Both wrap to 0.
- Tile counters replace division: tile_px 0..29 and tile_col 0..15 advance only while hcount in 80..559; tile_py 0..29 and tile_row 0..15 advance once per line while vcount<480. All clear at hcount=0 (column) / vcount=0 (row). tile_col does not advance past 15.
- Load FSM: IDLE -> PENDING on maze_done 0->1 (edge detect register, reset 0). PENDING -> LOAD when hcount=799 and vcount=524 (last cycle of frame). LOAD copies maze_data into snapshot for one cycle, returns IDLE. New edges in PENDING are absorbed (stay PENDING). Display always reads snapshot, never maze_data directly — no tearing.
- Pixel colour priority: blanking (outside 640x480) -> 8'h00; outside maze area (hcount<80 or >=560) -> 8'h00; player tile (tile_col==player_x && tile_row==player_y) and snapshot cell is path -> 8'hE0; path -> 8'hFF; wall -> 8'h03. player_x/player_y sampled in stage 1.
- Player on a wall cell is drawn as wall (not red).

## Timing
- Stage 0: counters. Stage 1: register tile indices, snapshot bit, region flags, raw syncs. Stage 2: register rgb, hsync, vsync. Outputs lag counter values by exactly 2 cycles; hsync/vsync delayed identically so sync-to-pixel alignment matches standard 640x480 timing.
- hsync low for 96 cycles per line; vsync low for 2 lines (1600 cycles) per frame.
- frame_start high for the cycle rgb shows pixel (0,0).
- Snapshot update takes effect on the first pixel of the next frame; worst-case latency from maze_done edge to visible = one full frame + 2 cycles.
- rst_n low mid-frame: everything returns to reset values next edge; snapshot cleared (screen all wall after reset).

## Configuration
- MAZE_RENDER_GRID_EN defined: pixels with tile_px==0 or tile_py==0 inside the maze area render 8'h49 (grey grid line), overriding path/wall/player.
- Undefined: no grid, tiles are solid colour; grid compare logic absent.

## Structure
- Shared package maze_pkg: VGA timing constants (H_VIS, H_FP, H_SYNC, H_TOTAL, V_*), colour constants (COL_PATH, COL_WALL, COL_PLAYER, COL_BLANK, COL_GRID), MAZE_DIM=16, load FSM state enum.
- One sub-module: vga_timing (hcount, vcount, raw syncs, visible flag); tile counters, load FSM and pixel pipeline in top.

## Test plan
- Reset then run 2 frames -> hsync period 800 cycles, low 96; vsync period 420000 cycles, low 1600; rgb=0 during blanking.
- maze_data all ones, maze_done rise -> first frame still all-wall (8'h03 in maze area), second frame 8'hFF in area, 8'h00 in columns 0..79 and 560..639.
- maze_data only bit 17 set (cell 1,1), player (1,1) -> pixels x=110..139, y=30..59 are 8'hE0; player (0,0) -> same pixels 8'hFF, cell (0,0) 8'h03.
- Two maze_done pulses within one frame -> single snapshot at frame end reflecting maze_data at that cycle.
- rst_n low at vcount=200 for one cycle -> counters 0, syncs high, rgb 0, snapshot cleared.
- With MAZE_RENDER_GRID_EN: pixel (80,0) and (110,45) = 8'h49; without: (110,45) follows cell colour.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared constants, colours and types for the maze VGA renderer.
// MAZE_RENDER_GRID_EN adds a grid-line flag to the stage-1 pixel record.
package maze_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int MAZE_DIM = 16;
  localparam int TILE_PX  = 30;
  localparam int X_ORG    = 80;
  localparam int X_END    = X_ORG + MAZE_DIM * TILE_PX;

  localparam logic [7:0] COL_BLANK  = 8'h00;
  localparam logic [7:0] COL_WALL   = 8'h03;
  localparam logic [7:0] COL_PATH   = 8'hFF;
  localparam logic [7:0] COL_PLAYER = 8'hE0;
  localparam logic [7:0] COL_GRID   = 8'h49;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_PENDING,
    LD_LOAD
  } load_state_e;

  typedef struct packed {
    logic vis;
    logic area;
    logic path;
    logic player;
`ifdef MAZE_RENDER_GRID_EN
    logic grid;
`endif
    logic hs;
    logic vs;
    logic first;
  } pix_s1_t;

endpackage

// File: rtl/maze_renderer_vga_timing.sv
// VGA raster counters with raw (undelayed) syncs and visible-area flag.
// Blanking intervals and visible height are parameters; defaults give 640x480@60.
module vga_timing
  import maze_pkg::*;
#(
  parameter int HFP  = H_FP,
  parameter int HSW  = H_SYNC,
  parameter int HBP  = H_BP,
  parameter int VVIS = V_VIS,
  parameter int VFP  = V_FP,
  parameter int VSW  = V_SYNC,
  parameter int VBP  = V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       visible,
  output logic       line_end,
  output logic       frame_end
);

  localparam logic [9:0] H_LAST  = 10'(H_VIS + HFP + HSW + HBP - 1);
  localparam logic [9:0] V_LAST  = 10'(VVIS + VFP + VSW + VBP - 1);
  localparam logic [9:0] HS_BEG  = 10'(H_VIS + HFP);
  localparam logic [9:0] HS_END  = 10'(H_VIS + HFP + HSW);
  localparam logic [9:0] VS_BEG  = 10'(VVIS + VFP);
  localparam logic [9:0] VS_END  = 10'(VVIS + VFP + VSW);
  localparam logic [9:0] H_VIS10 = 10'(H_VIS);
  localparam logic [9:0] V_VIS10 = 10'(VVIS);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;

  always_comb begin
    line_end  = (hcount_q == H_LAST);
    frame_end = line_end && (vcount_q == V_LAST);
    hcount_d  = line_end ? '0 : hcount_q + 10'd1;
    vcount_d  = vcount_q;
    if (line_end) vcount_d = frame_end ? '0 : vcount_q + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign hsync_raw = !((hcount_q >= HS_BEG) && (hcount_q < HS_END));
  assign vsync_raw = !((vcount_q >= VS_BEG) && (vcount_q < VS_END));
  assign visible   = (hcount_q < H_VIS10) && (vcount_q < V_VIS10);

endmodule

// File: rtl/maze_renderer.sv
// Snapshots the carved maze on maze_done and scans it out as 16x16 tiles over VGA.
// MAZE_RENDER_GRID_EN: draw grey grid lines on the first row/column of every tile.
module maze_renderer
  import maze_pkg::*;
#(
  parameter int HFP  = H_FP,
  parameter int HSW  = H_SYNC,
  parameter int HBP  = H_BP,
  parameter int VVIS = V_VIS,
  parameter int VFP  = V_FP,
  parameter int VSW  = V_SYNC,
  parameter int VBP  = V_BP
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] maze_data,
  input  logic         maze_done,
  input  logic [3:0]   player_x,
  input  logic [3:0]   player_y,
  output logic         hsync,
  output logic         vsync,
  output logic [7:0]   rgb,
  output logic         frame_start
);

  localparam logic [9:0] X_ORG10  = 10'(X_ORG);
  localparam logic [9:0] X_END10  = 10'(X_END);
  localparam logic [9:0] V_VIS10  = 10'(VVIS);
  localparam logic [4:0] PX_LAST  = 5'(TILE_PX - 1);
  localparam logic [3:0] IDX_LAST = 4'(MAZE_DIM - 1);

  logic [9:0] hcount, vcount;
  logic       hsync_raw, vsync_raw, visible, line_end, frame_end;

  vga_timing #(
    .HFP(HFP), .HSW(HSW), .HBP(HBP), .VVIS(VVIS), .VFP(VFP), .VSW(VSW), .VBP(VBP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .hcount    (hcount),
    .vcount    (vcount),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .visible   (visible),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  logic in_area;
  assign in_area = (hcount >= X_ORG10) && (hcount < X_END10);

  // Tile counters track the pixel currently in hcount/vcount, so no divider is needed.
  logic [4:0] tile_px_q, tile_px_d, tile_py_q, tile_py_d;
  logic [3:0] tile_col_q, tile_col_d, tile_row_q, tile_row_d;

  always_comb begin
    tile_px_d  = tile_px_q;
    tile_col_d = tile_col_q;
    tile_py_d  = tile_py_q;
    tile_row_d = tile_row_q;
    if (line_end) begin
      tile_px_d  = '0;
      tile_col_d = '0;
    end else if (in_area) begin
      if (tile_px_q == PX_LAST) begin
        tile_px_d = '0;
        if (tile_col_q != IDX_LAST) tile_col_d = tile_col_q + 4'd1;
      end else begin
        tile_px_d = tile_px_q + 5'd1;
      end
    end
    if (frame_end) begin
      tile_py_d  = '0;
      tile_row_d = '0;
    end else if (line_end && (vcount < V_VIS10)) begin
      if (tile_py_q == PX_LAST) begin
        tile_py_d = '0;
        if (tile_row_q != IDX_LAST) tile_row_d = tile_row_q + 4'd1;
      end else begin
        tile_py_d = tile_py_q + 5'd1;
      end
    end
  end

  // Load FSM: a completed maze is latched only across a frame boundary to avoid tearing.
  load_state_e  ld_state_q;
  logic         done_q;
  logic [255:0] snapshot_q;
  logic         done_rise;
  assign done_rise = maze_done && !done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_state_q <= LD_IDLE;
      done_q     <= 1'b0;
      snapshot_q <= '0;
    end else begin
      done_q <= maze_done;
      case (ld_state_q)
        LD_IDLE:    if (done_rise) ld_state_q <= LD_PENDING;
        LD_PENDING: if (frame_end) ld_state_q <= LD_LOAD;
        LD_LOAD: begin
          snapshot_q <= maze_data;
          ld_state_q <= done_rise ? LD_PENDING : LD_IDLE;
        end
        default:    ld_state_q <= LD_IDLE;
      endcase
    end
  end

  pix_s1_t s1_q, s1_d;

  always_comb begin
    s1_d        = '0;
    s1_d.vis    = visible;
    s1_d.area   = in_area;
    s1_d.path   = snapshot_q[{tile_row_q, tile_col_q}];
    s1_d.player = (tile_col_q == player_x) && (tile_row_q == player_y);
`ifdef MAZE_RENDER_GRID_EN
    s1_d.grid   = (tile_px_q == '0) || (tile_py_q == '0);
`endif
    s1_d.hs     = hsync_raw;
    s1_d.vs     = vsync_raw;
    s1_d.first  = (hcount == '0) && (vcount == '0);
  end

  logic [7:0] rgb_q, rgb_d;
  logic       hsync_q, vsync_q, frame_start_q;

  always_comb begin
    if (!s1_q.vis || !s1_q.area) rgb_d = COL_BLANK;
`ifdef MAZE_RENDER_GRID_EN
    else if (s1_q.grid)          rgb_d = COL_GRID;
`endif
    else if (!s1_q.path)         rgb_d = COL_WALL;
    else if (s1_q.player)        rgb_d = COL_PLAYER;
    else                         rgb_d = COL_PATH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tile_px_q     <= '0;
      tile_col_q    <= '0;
      tile_py_q     <= '0;
      tile_row_q    <= '0;
      s1_q          <= '0;
      s1_q.hs       <= 1'b1;
      s1_q.vs       <= 1'b1;
      rgb_q         <= COL_BLANK;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      tile_px_q     <= tile_px_d;
      tile_col_q    <= tile_col_d;
      tile_py_q     <= tile_py_d;
      tile_row_q    <= tile_row_d;
      s1_q          <= s1_d;
      rgb_q         <= rgb_d;
      hsync_q       <= s1_q.hs;
      vsync_q       <= s1_q.vs;
      frame_start_q <= s1_q.first;
    end
  end

  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule
